// File: rtl/contador_pkg.sv
// contador_pkg: shared types and constants for the contador_seq counter.
//   state_t  : FSM states of contador_seq
//   mode_t   : run modes (bounce, up-wrap, down-wrap, code 11 behaves as bounce)
//   CNT_W    : counter / endpoint / sweep width
//   CNT_ONE  : width-matched constant one for step arithmetic
package contador_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_UP      = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_DOWN    = 3'd3,
        ST_HOLD_LO = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_BOUNCE     = 2'b00,
        MODE_UP_WRAP    = 2'b01,
        MODE_DOWN_WRAP  = 2'b10,
        MODE_BOUNCE_ALT = 2'b11
    } mode_t;

endpackage

// File: rtl/updown_cnt4.sv
// updown_cnt4: loadable up/down counter, the datapath of contador_seq.
// Ports:
//   clock    in  rising-edge clock
//   clear_n  in  async active-low clear (s -> 0)
//   load     in  load load_val into s (has priority over en)
//   load_val in  value to load
//   en       in  step s by one this edge
//   dir      in  step direction: 0 increment, 1 decrement
//   s        out counter value
module updown_cnt4
    import contador_pkg::*;
(
    input  logic             clock,
    input  logic             clear_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [CNT_W-1:0] s
);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            s <= '0;
        end else if (load) begin
            s <= load_val;
        end else if (en) begin
            s <= dir ? (s - CNT_ONE) : (s + CNT_ONE);
        end
    end

endmodule

// File: rtl/contador_seq.sv
// contador_seq: sequencing counter sweeping s between latched endpoints lo..hi
// in bounce, up-wrap or down-wrap mode, finishing after a programmed number of
// endpoint arrivals (sweeps; 0 = run until stop).
// Build option: CONTADOR_SEQ_HOLD_EN adds HOLD_HI/HOLD_LO, so in bounce mode
// the endpoint is repeated for one cycle before reversing.
// Ports:
//   clock     in  rising-edge clock
//   clear_n   in  async active-low reset
//   start     in  level request to begin a run, sampled only in IDLE
//   stop      in  abort request, sampled in any run state
//   mode      in  00 bounce, 01 up-wrap, 10 down-wrap, 11 bounce
//   lo, hi    in  endpoints, latched when a start is accepted (needs lo < hi)
//   sweeps    in  endpoint arrivals before done, latched at start
//   s         out counter value
//   dir       out 0 counting up, 1 counting down
//   busy      out high in any run state
//   done      out one-cycle pulse at run completion
//   err       out one-cycle pulse when a start is rejected (lo >= hi)
//   dbg_state out current FSM state
module contador_seq
    import contador_pkg::*;
(
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] lo,
    input  logic [CNT_W-1:0] hi,
    input  logic [CNT_W-1:0] sweeps,
    output logic [CNT_W-1:0] s,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       dbg_state
);

    state_t           state, state_n;
    mode_t            mode_q, mode_n;
    logic [CNT_W-1:0] lo_q, lo_n, hi_q, hi_n, sweeps_q, sweeps_n;
    logic [CNT_W-1:0] sweep_cnt, cnt_n;
    logic             dir_n, done_n, err_n;
    logic             load, en, arrive, is_wrap;
    logic [CNT_W-1:0] load_val, s_inc, s_dec;

    updown_cnt4 u_dp (
        .clock    (clock),
        .clear_n  (clear_n),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .dir      (dir),
        .s        (s)
    );

    assign s_inc     = s + CNT_ONE;
    assign s_dec     = s - CNT_ONE;
    assign is_wrap   = (mode_q == MODE_UP_WRAP) || (mode_q == MODE_DOWN_WRAP);
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_BOUNCE;
            lo_q      <= '0;
            hi_q      <= '0;
            sweeps_q  <= '0;
            sweep_cnt <= '0;
            dir       <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            mode_q    <= mode_n;
            lo_q      <= lo_n;
            hi_q      <= hi_n;
            sweeps_q  <= sweeps_n;
            sweep_cnt <= cnt_n;
            dir       <= dir_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        mode_n   = mode_q;
        lo_n     = lo_q;
        hi_n     = hi_q;
        sweeps_n = sweeps_q;
        cnt_n    = sweep_cnt;
        dir_n    = dir;
        done_n   = 1'b0;
        err_n    = 1'b0;
        load     = 1'b0;
        load_val = s;
        en       = 1'b0;
        arrive   = 1'b0;

        case (state)
            ST_IDLE: begin
                // start together with stop is ignored entirely.
                if (start && !stop) begin
                    if (lo < hi) begin
                        mode_n   = mode_t'(mode);
                        lo_n     = lo;
                        hi_n     = hi;
                        sweeps_n = sweeps;
                        cnt_n    = '0;
                        load     = 1'b1;
                        if (mode_t'(mode) == MODE_DOWN_WRAP) begin
                            load_val = hi;
                            dir_n    = 1'b1;
                            state_n  = ST_DOWN;
                        end else begin
                            load_val = lo;
                            dir_n    = 1'b0;
                            state_n  = ST_UP;
                        end
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end

            ST_UP: begin
                // Wrap reload is not an arrival; only a step onto hi is.
                if (mode_q == MODE_UP_WRAP && s == hi_q) begin
                    load     = 1'b1;
                    load_val = lo_q;
                end else begin
                    en     = 1'b1;
                    arrive = (s_inc == hi_q);
                end
                if (arrive && !is_wrap) begin
`ifdef CONTADOR_SEQ_HOLD_EN
                    state_n = ST_HOLD_HI;
`else
                    state_n = ST_DOWN;
                    dir_n   = 1'b1;
`endif
                end
            end

            ST_DOWN: begin
                if (mode_q == MODE_DOWN_WRAP && s == lo_q) begin
                    load     = 1'b1;
                    load_val = hi_q;
                end else begin
                    en     = 1'b1;
                    arrive = (s_dec == lo_q);
                end
                if (arrive && !is_wrap) begin
`ifdef CONTADOR_SEQ_HOLD_EN
                    state_n = ST_HOLD_LO;
`else
                    state_n = ST_UP;
                    dir_n   = 1'b0;
`endif
                end
            end

`ifdef CONTADOR_SEQ_HOLD_EN
            ST_HOLD_HI: begin
                state_n = ST_DOWN;
                dir_n   = 1'b1;
            end

            ST_HOLD_LO: begin
                state_n = ST_UP;
                dir_n   = 1'b0;
            end
`endif

            default: state_n = ST_IDLE;
        endcase

        if (arrive) begin
            cnt_n = sweep_cnt + CNT_ONE;
        end

        // Completion beats stop: s still steps onto the endpoint this edge.
        if (arrive && sweeps_q != '0 && cnt_n == sweeps_q) begin
            state_n = ST_IDLE;
            dir_n   = dir;
            done_n  = 1'b1;
        end else if (stop && state != ST_IDLE) begin
            state_n = ST_IDLE;
            dir_n   = dir;
            cnt_n   = sweep_cnt;
            load    = 1'b0;
            en      = 1'b0;
        end
    end

endmodule

// File: tb/tb_contador_seq.sv
// tb_contador_seq: self-checking bench for contador_seq. Expected counter
// sequences go into exp_q when a run is started and are popped one per clock
// as the DUT produces them. Inputs are driven and outputs sampled 1 time unit
// after each rising edge.
module tb_contador_seq;

    logic       clock = 1'b0;
    logic       clear_n, start, stop, dir, busy, done, err;
    logic [1:0] mode;
    logic [3:0] lo, hi, sweeps, s;
    logic [2:0] dbg_state;

    logic [3:0] exp_q[$];
    logic [3:0] exp_s, s_model;
    logic       last;
    int         n_cmp = 0;
    int         n_bad = 0;

    contador_seq dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .lo        (lo),
        .hi        (hi),
        .sweeps    (sweeps),
        .s         (s),
        .dir       (dir),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- driver ----------------
    task automatic start_run(input logic [1:0] m, input logic [3:0] l, input logic [3:0] h,
                             input logic [3:0] sw);
        mode = m; lo = l; hi = h; sweeps = sw; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_n = 1'b0; start = 1'b0; stop = 1'b0;
        mode = 2'b00; lo = '0; hi = '0; sweeps = '0;
        #3;
        n_cmp++; if (s !== 4'd0) begin n_bad++; $display("FAIL reset_s: got %0d want 0", s); end
        n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL reset_dir: got %b want 0", dir); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        tick();
        tick();
        clear_n = 1'b1;
        s_model = 4'd0;
    endtask

    // Bounce lo=0 hi=3 sweeps=2, started on the first edge after reset release.
    task automatic test_bounce();
`ifdef CONTADOR_SEQ_HOLD_EN
        exp_q = {4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
`else
        exp_q = {4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0};
`endif
        start_run(2'b00, 4'd0, 4'd3, 4'd2);
        while (exp_q.size() > 0) begin
            exp_s = exp_q.pop_front();
            last  = (exp_q.size() == 0);
            n_cmp++; if (s !== exp_s) begin n_bad++; $display("FAIL bounce_s: got %0d want %0d", s, exp_s); end
            n_cmp++; if (done !== last) begin n_bad++; $display("FAIL bounce_done: got %b want %b", done, last); end
            n_cmp++; if (busy !== !last) begin n_bad++; $display("FAIL bounce_busy: got %b want %b", busy, !last); end
            if (!last) tick();
        end
        tick();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL bounce_after: busy=%b done=%b want 0 0", busy, done); end
        s_model = 4'd0;
    endtask

    // Up-wrap lo=2 hi=4 sweeps=2, with a start attempted while busy.
    task automatic test_up_wrap();
        int i;
        exp_q = {4'd2, 4'd3, 4'd4, 4'd2, 4'd3, 4'd4};
        start_run(2'b01, 4'd2, 4'd4, 4'd2);
        i = 0;
        while (exp_q.size() > 0) begin
            exp_s = exp_q.pop_front();
            last  = (exp_q.size() == 0);
            n_cmp++; if (s !== exp_s) begin n_bad++; $display("FAIL upwrap_s: got %0d want %0d", s, exp_s); end
            n_cmp++; if (done !== last) begin n_bad++; $display("FAIL upwrap_done: got %b want %b", done, last); end
            n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL upwrap_dir: got %b want 0", dir); end
            if (i == 1) begin start = 1'b1; mode = 2'b10; lo = 4'd0; hi = 4'd9; end
            if (i == 3) start = 1'b0;
            i++;
            if (!last) tick();
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL upwrap_busy_end: got %b want 0", busy); end
        s_model = 4'd4;
    endtask

    task automatic test_err();
        mode = 2'b00; lo = 4'd5; hi = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_eq_pulse: got %b want 1", err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL err_eq_busy: got %b want 0", busy); end
        n_cmp++; if (s !== s_model) begin n_bad++; $display("FAIL err_eq_s: got %0d want %0d", s, s_model); end
        tick();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_eq_single: got %b want 0", err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL err_eq_busy2: got %b want 0", busy); end
        lo = 4'd9; hi = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_gt_pulse: got %b want 1", err); end
        n_cmp++; if (s !== s_model) begin n_bad++; $display("FAIL err_gt_s: got %0d want %0d", s, s_model); end
        tick();
    endtask

    task automatic test_start_stop_idle();
        mode = 2'b00; lo = 4'd1; hi = 4'd8; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ss_idle_err: got %b want 0", err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ss_idle_busy: got %b want 0", busy); end
        n_cmp++; if (s !== s_model) begin n_bad++; $display("FAIL ss_idle_s: got %0d want %0d", s, s_model); end
    endtask

    // Down-wrap lo=1 hi=3 sweeps=2: 3,2,1,3,2,1.
    task automatic test_down_wrap();
        exp_q = {4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1};
        start_run(2'b10, 4'd1, 4'd3, 4'd2);
        while (exp_q.size() > 0) begin
            exp_s = exp_q.pop_front();
            last  = (exp_q.size() == 0);
            n_cmp++; if (s !== exp_s) begin n_bad++; $display("FAIL dnwrap_s: got %0d want %0d", s, exp_s); end
            n_cmp++; if (done !== last) begin n_bad++; $display("FAIL dnwrap_done: got %b want %b", done, last); end
            n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL dnwrap_dir: got %b want 1", dir); end
            if (!last) tick();
        end
        s_model = 4'd1;
    endtask

    // Mode 11 behaves as bounce: lo=5 hi=7 sweeps=3.
    task automatic test_mode11();
`ifdef CONTADOR_SEQ_HOLD_EN
        exp_q = {4'd5, 4'd6, 4'd7, 4'd7, 4'd6, 4'd5, 4'd5, 4'd6, 4'd7};
`else
        exp_q = {4'd5, 4'd6, 4'd7, 4'd6, 4'd5, 4'd6, 4'd7};
`endif
        start_run(2'b11, 4'd5, 4'd7, 4'd3);
        while (exp_q.size() > 0) begin
            exp_s = exp_q.pop_front();
            last  = (exp_q.size() == 0);
            n_cmp++; if (s !== exp_s) begin n_bad++; $display("FAIL mode11_s: got %0d want %0d", s, exp_s); end
            n_cmp++; if (done !== last) begin n_bad++; $display("FAIL mode11_done: got %b want %b", done, last); end
            if (!last) tick();
        end
        s_model = 4'd7;
    endtask

    // stop raised on the same edge as the completing arrival: done still fires.
    task automatic test_stop_completion();
        int i;
        exp_q = {4'd2, 4'd3, 4'd4};
        start_run(2'b01, 4'd2, 4'd4, 4'd1);
        i = 0;
        while (exp_q.size() > 0) begin
            exp_s = exp_q.pop_front();
            last  = (exp_q.size() == 0);
            n_cmp++; if (s !== exp_s) begin n_bad++; $display("FAIL stopdone_s: got %0d want %0d", s, exp_s); end
            n_cmp++; if (done !== last) begin n_bad++; $display("FAIL stopdone_done: got %b want %b", done, last); end
            if (i == 1) stop = 1'b1;
            i++;
            if (!last) tick();
        end
        stop = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stopdone_busy: got %b want 0", busy); end
        s_model = 4'd4;
    endtask

    // Bounce 0..15 with sweeps=0, aborted when s reaches 9.
    task automatic test_stop();
        for (int v = 0; v <= 9; v++) exp_q.push_back(4'(v));
        start_run(2'b00, 4'd0, 4'd15, 4'd0);
        while (exp_q.size() > 0) begin
            exp_s = exp_q.pop_front();
            n_cmp++; if (s !== exp_s) begin n_bad++; $display("FAIL stop_run_s: got %0d want %0d", s, exp_s); end
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stop_run_busy: got %b want 1", busy); end
            if (exp_q.size() == 0) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        n_cmp++; if (s !== 4'd9) begin n_bad++; $display("FAIL stop_hold_s: got %0d want 9", s); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stop_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL stop_done: got %b want 0", done); end
        tick();
        n_cmp++; if (s !== 4'd9 || done !== 1'b0) begin n_bad++; $display("FAIL stop_frozen: s=%0d done=%b want 9 0", s, done); end
    endtask

    // Async clear at s=7 mid-run, then restart from a new lo.
    task automatic test_clear_mid_run();
        for (int v = 0; v <= 7; v++) exp_q.push_back(4'(v));
        start_run(2'b00, 4'd0, 4'd15, 4'd0);
        while (exp_q.size() > 0) begin
            exp_s = exp_q.pop_front();
            n_cmp++; if (s !== exp_s) begin n_bad++; $display("FAIL clr_run_s: got %0d want %0d", s, exp_s); end
            if (exp_q.size() > 0) tick();
        end
        #2 clear_n = 1'b0;
        #1;
        n_cmp++; if (s !== 4'd0) begin n_bad++; $display("FAIL clr_async_s: got %0d want 0", s); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_async_busy: got %b want 0", busy); end
        n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL clr_async_dir: got %b want 0", dir); end
        tick();
        clear_n = 1'b1;
        start_run(2'b00, 4'd3, 4'd6, 4'd0);
        n_cmp++; if (s !== 4'd3) begin n_bad++; $display("FAIL clr_restart_s: got %0d want 3", s); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL clr_restart_busy: got %b want 1", busy); end
        tick();
        n_cmp++; if (s !== 4'd4) begin n_bad++; $display("FAIL clr_step_s: got %0d want 4", s); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_stop_busy: got %b want 0", busy); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_bounce();
        test_up_wrap();
        test_err();
        test_start_stop_idle();
        test_down_wrap();
        test_mode11();
        test_stop_completion();
        test_stop();
        test_clear_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #20000;
        $display("FAIL timeout: simulation time limit reached, got no end want end");
        $fatal(1, "timeout");
    end

endmodule
